// File: rtl/fir_pkg.sv
// Shared constants, types and coefficients for the time-multiplexed 8-tap FIR.
// The output width assumes exactly 8 taps (3 growth bits on top of the 24-bit product).
package fir_pkg;

    localparam int TAPS   = 8;
    localparam int DIN_W  = 12;
    localparam int COEF_W = 12;
    localparam int DOUT_W = 27;
    localparam int CNT_W  = 3;
    localparam int PROD_W = DIN_W + COEF_W;

    typedef logic signed [DIN_W-1:0]  sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [DOUT_W-1:0] acc_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Symmetric low-pass taps, DC gain 1026.
    localparam coef_t COEF [TAPS] = '{
        -12'sd12, 12'sd35, 12'sd180, 12'sd310,
        12'sd310, 12'sd180, 12'sd35, -12'sd12
    };

endpackage

// File: rtl/fir_mac.sv
// Combinational multiply-accumulate step: sum = acc + x*h.
// The 24-bit signed product is sign-extended to the accumulator width.
module fir_mac
    import fir_pkg::*;
(
    input  logic signed [DOUT_W-1:0] acc,
    input  logic signed [DIN_W-1:0]  x,
    input  logic signed [COEF_W-1:0] h,
    output logic signed [DOUT_W-1:0] sum
);

    logic signed [PROD_W-1:0] prod;

    assign prod = x * h;
    assign sum  = acc + DOUT_W'(prod);

endmodule

// File: rtl/serial_fir.sv
// Serial 8-tap FIR: one MAC walks the delay line over 8 clocks per output.
// A new sample may be accepted on the same edge that finishes the previous output.
module serial_fir
    import fir_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     en_i,
    input  logic [DIN_W-1:0]         data_i,
    output logic signed [DOUT_W-1:0] data_o
);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    sample_t              x [TAPS];
    acc_t                 acc;
    acc_t                 mac_sum;
    logic                 last;
    logic                 accept;

    assign last   = (state == RUN) && (cnt == CNT_W'(TAPS - 1));
    assign accept = en_i && ((state == IDLE) || last);

    fir_mac u_mac (
        .acc (acc),
        .x   (x[cnt]),
        .h   (COEF[cnt]),
        .sum (mac_sum)
    );

    // The final tap's MAC result goes straight to data_o, so the accumulator
    // is free to restart on that same edge when a new sample arrives.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            data_o <= '0;
            for (int k = 0; k < TAPS; k++) begin
                x[k] <= '0;
            end
        end else begin
            if (last) begin
                data_o <= mac_sum;
            end
            if (accept) begin
                x[0] <= sample_t'(data_i);
                for (int k = 1; k < TAPS; k++) begin
                    x[k] <= x[k-1];
                end
                acc   <= '0;
                cnt   <= '0;
                state <= RUN;
            end else if (state == RUN) begin
                if (last) begin
                    state <= IDLE;
                end else begin
                    acc <= mac_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_fir.sv
// Directed and randomized checks of serial_fir against an independent convolution model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_serial_fir;

    logic               clk = 1'b0;
    logic               rstn;
    logic               en;
    logic [11:0]        data;
    logic signed [26:0] data_o;

    localparam int H [8] = '{-12, 35, 180, 310, 310, 180, 35, -12};

    int nChecks = 0;
    int nErrors = 0;

    logic signed [11:0] hist [8];
    logic signed [26:0] pendExp;
    logic signed [26:0] lastExp;
    bit                 havePend;

    always #5 clk = ~clk;

    serial_fir dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .en_i   (en),
        .data_i (data),
        .data_o (data_o)
    );

    task automatic checkOutput(input string tag, input logic signed [26:0] got,
                               input logic signed [26:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: data_o=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [11:0] d);
        en   = e;
        data = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void shiftModel(input logic signed [11:0] d);
        for (int k = 7; k > 0; k--) begin
            hist[k] = hist[k-1];
        end
        hist[0] = d;
    endfunction

    function automatic logic signed [26:0] modelOut();
        longint s = 0;
        for (int k = 0; k < 8; k++) begin
            s += longint'(hist[k]) * longint'(H[k]);
        end
        return 27'(s);
    endfunction

    function automatic void clearModel();
        for (int k = 0; k < 8; k++) begin
            hist[k] = '0;
        end
        havePend = 1'b0;
        lastExp  = '0;
        pendExp  = '0;
    endfunction

    // One sample every 8 cycles; the accept edge also completes the previous output.
    task automatic feed(input logic signed [11:0] d, input logic signed [26:0] exp,
                        input string tag);
        applyStimulus(1'b1, d);
        if (havePend) begin
            checkOutput(tag, data_o, pendExp);
            lastExp = pendExp;
        end
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b0, 12'd0);
            if (c == 3) checkOutput({tag, "_hold"}, data_o, lastExp);
        end
        pendExp  = exp;
        havePend = 1'b1;
    endtask

    task automatic flush(input string tag);
        applyStimulus(1'b0, 12'd0);
        if (havePend) begin
            checkOutput(tag, data_o, pendExp);
            lastExp  = pendExp;
            havePend = 1'b0;
        end
    endtask

    task automatic impulseTest(input string tag);
        for (int i = 0; i < 8; i++) begin
            logic signed [11:0] d;
            d = (i == 0) ? 12'sd1 : 12'sd0;
            shiftModel(d);
            feed(d, 27'(H[i]), tag);
        end
        flush(tag);
    endtask

    initial begin
        logic signed [11:0] d;
        rstn = 1'b0;
        en   = 1'b0;
        data = '0;
        clearModel();

        // Reset held with random stimulus, then quiet release.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 12'($urandom));
            checkOutput("reset_hold", data_o, 27'sd0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 12'd0);
            checkOutput("reset_release", data_o, 27'sd0);
        end

        impulseTest("impulse");

        for (int i = 0; i < 9; i++) begin
            shiftModel(12'sd2047);
            feed(12'sd2047, modelOut(), "step_pos");
        end
        flush("step_pos");
        checkOutput("step_pos_final", data_o, 27'sd2100222);
        for (int i = 0; i < 9; i++) begin
            shiftModel(-12'sd2048);
            feed(-12'sd2048, modelOut(), "step_neg");
        end
        flush("step_neg");
        checkOutput("step_neg_final", data_o, -27'sd2101248);

        // en held high: only every 8th ramp value is taken.
        for (int c = 0; c < 48; c++) begin
            applyStimulus(1'b1, 12'(c + 100));
            if (c % 8 == 0) begin
                if (havePend) checkOutput("throughput", data_o, pendExp);
                shiftModel(12'(c + 100));
                pendExp  = modelOut();
                havePend = 1'b1;
            end
        end
        flush("throughput");

        // Abort a computation at cnt==4; en is high but must be ignored.
        applyStimulus(1'b1, 12'd500);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 12'd0);
        rstn = 1'b0;
        applyStimulus(1'b1, 12'd77);
        checkOutput("midrun_reset", data_o, 27'sd0);
        rstn = 1'b1;
        clearModel();
        impulseTest("post_reset_impulse");

        for (int i = 0; i < 2000; i++) begin
            d = 12'($urandom);
            shiftModel(d);
            feed(d, modelOut(), "random");
        end
        flush("random");

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
